// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space invaders video pipeline:
// colour codes for the priority mixer, screen geometry and laser FSM encoding.
package space_invaders_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = COORD_W + 1;

    typedef logic [2:0] color_t;

    localparam color_t BACKGROUND = 3'd0;
    localparam color_t SPACESHIP  = 3'd1;
    localparam color_t ALIENS0    = 3'd2;
    localparam color_t ALIENS1    = 3'd3;
    localparam color_t ALIENS2    = 3'd4;
    localparam color_t ALIENS3    = 3'd5;
    localparam color_t LASER      = 3'd6;
    localparam color_t NONE       = 3'd7;

    localparam int unsigned SCREEN_WIDTH  = 640;
    localparam int unsigned SCREEN_HEIGHT = 480;
    localparam int unsigned H_OFFSET      = 10;
    localparam int unsigned V_OFFSET      = 10;
    localparam int unsigned SHIP_WIDTH    = 40;
    localparam int unsigned SHIP_HEIGHT   = 30;

    typedef logic [1:0] laser_state_t;

    localparam laser_state_t LS_IDLE     = 2'd0;
    localparam laser_state_t LS_FLYING   = 2'd1;
    localparam laser_state_t LS_COOLDOWN = 2'd2;

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test; rectangle given by x centre, top y,
// width and height. All bounds are formed in one extra bit so nothing wraps.
module rect_hit
    import space_invaders_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned HEIGHT = 12
) (
    input  logic [COORD_W-1:0] px_i,
    input  logic [COORD_W-1:0] py_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] top_i,
    output logic               inside_o
);

    logic [SUM_W-1:0] px_ext;
    logic [SUM_W-1:0] py_ext;
    logic [SUM_W-1:0] left;
    logic [SUM_W-1:0] right;
    logic [SUM_W-1:0] top;
    logic [SUM_W-1:0] bottom;

    assign px_ext = {1'b0, px_i};
    assign py_ext = {1'b0, py_i};
    // Callers guarantee cx_i >= WIDTH/2, so the left bound cannot underflow.
    assign left   = {1'b0, cx_i} - SUM_W'(WIDTH / 2);
    assign right  = {1'b0, cx_i} + SUM_W'(WIDTH / 2);
    assign top    = {1'b0, top_i};
    assign bottom = {1'b0, top_i} + SUM_W'(HEIGHT);

    assign inside_o = (px_ext >= left) && (px_ext < right) &&
                      (py_ext >= top)  && (py_ext < bottom);

endmodule

// File: rtl/laser_shot.sv
// Player laser: launches one shot from the ship's gun line on a fire edge,
// climbs it once per frame tick, retires it on hit or playfield exit.
module laser_shot #(
    parameter int unsigned SCREEN_WIDTH   = space_invaders_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT  = space_invaders_pkg::SCREEN_HEIGHT,
    parameter int unsigned SHIP_HEIGHT    = space_invaders_pkg::SHIP_HEIGHT,
    parameter int unsigned V_OFFSET       = space_invaders_pkg::V_OFFSET,
    parameter int unsigned LASER_WIDTH    = 4,
    parameter int unsigned LASER_HEIGHT   = 12,
    parameter int unsigned LASER_STEP     = 8,
    parameter int unsigned COOLDOWN_TICKS = 4,
    parameter logic [2:0]  LASER          = space_invaders_pkg::LASER,
    parameter logic [2:0]  NONE           = space_invaders_pkg::NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fire,
    input  logic       hit,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic [9:0] laserH,
    output logic [9:0] laserV,
    output logic       active,
    output logic [2:0] color
);

    localparam int unsigned COORD_W = space_invaders_pkg::COORD_W;
    localparam int unsigned SUM_W   = space_invaders_pkg::SUM_W;
    localparam int unsigned CNT_W   = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    localparam space_invaders_pkg::laser_state_t ST_IDLE     = space_invaders_pkg::LS_IDLE;
    localparam space_invaders_pkg::laser_state_t ST_FLYING   = space_invaders_pkg::LS_FLYING;
    localparam space_invaders_pkg::laser_state_t ST_COOLDOWN = space_invaders_pkg::LS_COOLDOWN;

    space_invaders_pkg::laser_state_t state_q, state_d;
    logic               fire_q;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] laser_h_q, laser_h_d;
    logic [COORD_W-1:0] laser_v_q, laser_v_d;
    logic               active_q, active_d;
    logic [2:0]         color_q, color_d;

    logic fire_edge;
    logic exits_screen;
    logic in_rect;

    assign fire_edge    = fire & ~fire_q;
    assign exits_screen = ({1'b0, laser_v_q} + SUM_W'(LASER_STEP + LASER_HEIGHT))
                          > SUM_W'(SCREEN_HEIGHT - V_OFFSET);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        laser_h_d = laser_h_q;
        laser_v_d = laser_v_q;
        active_d  = active_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && pending_q) begin
                    laser_h_d = gunPosition;
                    laser_v_d = COORD_W'(V_OFFSET + SHIP_HEIGHT);
                    pending_d = 1'b0;
                    active_d  = 1'b1;
                    state_d   = ST_FLYING;
                end else if (fire_edge) begin
                    pending_d = 1'b1;
                end
            end
            ST_FLYING: begin
                // A hit outranks the frame tick: the shot stops where it struck.
                if (hit) begin
                    active_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_COOLDOWN;
                end else if (enable) begin
                    if (exits_screen) begin
                        active_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_COOLDOWN;
                    end else begin
                        laser_v_d = laser_v_q + COORD_W'(LASER_STEP);
                    end
                end
            end
            ST_COOLDOWN: begin
                if (enable) begin
                    if (cnt_q == CNT_W'(COOLDOWN_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    rect_hit #(
        .WIDTH  (LASER_WIDTH),
        .HEIGHT (LASER_HEIGHT)
    ) u_rect_hit (
        .px_i     (hPos),
        .py_i     (vPos),
        .cx_i     (laser_h_q),
        .top_i    (laser_v_q),
        .inside_o (in_rect)
    );

    always_comb begin
        color_d = NONE;
        if (active_q && in_rect && ({1'b0, hPos} < SUM_W'(SCREEN_WIDTH))) begin
            color_d = LASER;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fire_q    <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            laser_h_q <= '0;
            laser_v_q <= '0;
            active_q  <= 1'b0;
            color_q   <= NONE;
        end else begin
            state_q   <= state_d;
            fire_q    <= fire;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            laser_h_q <= laser_h_d;
            laser_v_q <= laser_v_d;
            active_q  <= active_d;
            color_q   <= color_d;
        end
    end

    assign laserH = laser_h_q;
    assign laserV = laser_v_q;
    assign active = active_q;
    assign color  = color_q;

endmodule

// File: tb/tb_laser_shot.sv
// Directed bench for laser_shot: pixel-coverage table plus hand-written
// launch, flight, hit, lockout and reset sequences.
module tb_laser_shot;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fire;
    logic       hit;
    logic [9:0] gunPosition;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic [9:0] laserH;
    logic [9:0] laserV;
    logic       active;
    logic [2:0] color;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [2:0] c;
    } pix_vec_t;

    pix_vec_t vecs [8];

    always #5 clk = ~clk;

    laser_shot dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fire        (fire),
        .hit         (hit),
        .gunPosition (gunPosition),
        .hPos        (hPos),
        .vPos        (vPos),
        .laserH      (laserH),
        .laserV      (laserV),
        .active      (active),
        .color       (color)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    initial begin
        // Shot launched at x=320, top 40: covers x 318..321, y 40..51.
        vecs[0] = '{h: 10'd319, v: 10'd45, c: 3'd6};
        vecs[1] = '{h: 10'd322, v: 10'd45, c: 3'd7};
        vecs[2] = '{h: 10'd319, v: 10'd52, c: 3'd7};
        vecs[3] = '{h: 10'd318, v: 10'd40, c: 3'd6};
        vecs[4] = '{h: 10'd317, v: 10'd40, c: 3'd7};
        vecs[5] = '{h: 10'd321, v: 10'd51, c: 3'd6};
        vecs[6] = '{h: 10'd319, v: 10'd39, c: 3'd7};
        vecs[7] = '{h: 10'd0,   v: 10'd0,  c: 3'd7};

        reset = 1'b1; enable = 1'b0; fire = 1'b0; hit = 1'b0;
        gunPosition = 10'd320; hPos = 10'd0; vPos = 10'd0;
        step();
        step();
        reset = 1'b0;
        check("reset_active", active, 0);
        check("reset_laserH", laserH, 0);
        check("reset_laserV", laserV, 0);
        check("reset_color",  color, 7);

        // Launch on first enable after the fire edge.
        press();
        check("no_launch_before_enable", active, 0);
        tick();
        check("launch_active", active, 1);
        check("launch_laserH", laserH, 320);
        check("launch_laserV", laserV, 40);

        for (int i = 0; i < 8; i++) begin
            hPos = vecs[i].h;
            vPos = vecs[i].v;
            step();
            check($sformatf("pix%0d_color", i), color, vecs[i].c);
        end

        // Shot no longer follows the ship.
        gunPosition = 10'd200;
        tick();
        check("flight1_laserV", laserV, 48);
        check("flight1_laserH", laserH, 320);

        for (int i = 0; i < 51; i++) begin
            if (i == 10) press();
            tick();
        end
        check("tick52_laserV", laserV, 456);
        check("tick52_active", active, 1);
        tick();
        check("tick53_active", active, 0);
        check("tick53_laserV", laserV, 456);

        // Press after 3 cooldown ticks is discarded; 4th tick reaches IDLE.
        ticks(3);
        press();
        tick();
        check("cooldown_edge_discarded", active, 0);
        gunPosition = 10'd100;
        press();
        tick();
        check("relaunch_active", active, 1);
        check("relaunch_laserH", laserH, 100);
        check("relaunch_laserV", laserV, 40);

        ticks(5);
        check("pre_hit_laserV", laserV, 80);
        hit = 1'b1; enable = 1'b1;
        step();
        hit = 1'b0; enable = 1'b0;
        check("hit_active", active, 0);
        check("hit_laserV", laserV, 80);
        check("hit_laserH", laserH, 100);

        // Fire held from cooldown into IDLE must not launch.
        fire = 1'b1;
        step();
        ticks(6);
        check("held_fire_no_launch", active, 0);
        fire = 1'b0;
        step();
        gunPosition = 10'd150;
        press();
        tick();
        check("press_again_active", active, 1);
        check("press_again_laserH", laserH, 150);
        check("press_again_laserV", laserV, 40);

        ticks(20);
        check("midflight_laserV", laserV, 200);
        hPos = 10'd150; vPos = 10'd205;
        step();
        check("midflight_color", color, 6);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_active", active, 0);
        check("midreset_laserH", laserH, 0);
        check("midreset_laserV", laserV, 0);
        check("midreset_color",  color, 7);
        tick();
        check("midreset_no_pending", active, 0);
        press();
        tick();
        check("post_reset_launch", active, 1);
        check("post_reset_laserH", laserH, 150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
